// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the register-file writeback path.
package cpu_types_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned NREGS   = 32;
    localparam int unsigned WB_NREQ = 2;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // One writeback request: destination register and data
    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } wb_req_t;

    typedef enum logic {
        PREFER0 = 1'b0,
        PREFER1 = 1'b1
    } wb_arb_t;

    // One-hot register mask; register 0 is never marked
    function automatic logic [NREGS-1:0] reg_onehot(regbits_t r);
        reg_onehot = (r == '0) ? '0 : (NREGS'(1) << r);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-requester writeback FIFO; exposes queued destinations for the pending mask.
module wb_fifo
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  wb_req_t               din_i,
    output wb_req_t               dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output regbits_t [DEPTH-1:0]  entries_wsel_o,
    output logic [DEPTH-1:0]      valid_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]    valid_q;
    logic [AW-1:0]       rd_q;
    logic [AW-1:0]       wr_q;
    logic                do_push;
    logic                do_pop;

    assign full_o  = &valid_q;
    assign empty_o = ~|valid_q;
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign dout_o  = mem_q[rd_q];
    assign valid_o = valid_q;

    // Expose destination of each slot for the pending mask
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries_wsel_o[i] = mem_q[i].wsel;
        end
    end

    // Storage; contents only meaningful where valid_q is set
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    // Occupancy and pointers; flush empties the queue
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            if (do_push) begin
                valid_q[wr_q] <= 1'b1;
                wr_q          <= wr_q + AW'(1);
            end
            if (do_pop) begin
                valid_q[rd_q] <= 1'b0;
                rd_q          <= rd_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates two writeback requesters onto the single register-file write port.
// Optional macro RF_WB_FIXED_PRIORITY_EN: port 0 always wins on contention and
// the preference register is removed; otherwise round-robin.
module rf_wb_scheduler
    import cpu_types_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned NREQ       = WB_NREQ
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        flush,
    input  logic        wb0_valid,
    output logic        wb0_ready,
    input  logic [4:0]  wb0_wsel,
    input  logic [31:0] wb0_wdat,
    input  logic        wb1_valid,
    output logic        wb1_ready,
    input  logic [4:0]  wb1_wsel,
    input  logic [31:0] wb1_wdat,
    output logic        rf_WEN,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat,
    output logic        grant_id,
    output logic [31:0] pending,
    output logic        idle
);

    wb_req_t                   req0, req1, head0, head1, sel_req;
    regbits_t [FIFO_DEPTH-1:0] ent0, ent1;
    logic [FIFO_DEPTH-1:0]     vld0, vld1;
    logic                      full0, full1, empty0, empty1;
    logic [NREQ-1:0]           nonempty;
    logic                      pop, pick1;
    logic                      rf_wen_q;
    regbits_t                  rf_wsel_q;
    word_t                     rf_wdat_q;
    logic                      grant_q;
    logic [NREGS-1:0]          pending_c;

    assign req0 = {wb0_wsel, wb0_wdat};
    assign req1 = {wb1_wsel, wb1_wdat};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk            (clk),
        .n_rst          (n_rst),
        .flush_i        (flush),
        .push_i         (wb0_valid),
        .pop_i          (pop && !pick1),
        .din_i          (req0),
        .dout_o         (head0),
        .full_o         (full0),
        .empty_o        (empty0),
        .entries_wsel_o (ent0),
        .valid_o        (vld0)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk            (clk),
        .n_rst          (n_rst),
        .flush_i        (flush),
        .push_i         (wb1_valid),
        .pop_i          (pop && pick1),
        .din_i          (req1),
        .dout_o         (head1),
        .full_o         (full1),
        .empty_o        (empty1),
        .entries_wsel_o (ent1),
        .valid_o        (vld1)
    );

    assign wb0_ready = !full0;
    assign wb1_ready = !full1;
    assign nonempty  = NREQ'({!empty1, !empty0});
    assign pop       = (nonempty[0] || nonempty[1]) && !flush;
    assign sel_req   = pick1 ? head1 : head0;

`ifdef RF_WB_FIXED_PRIORITY_EN
    // Port 1 is served only when port 0 has nothing queued
    assign pick1 = nonempty[1] && !nonempty[0];
`else
    wb_arb_t arb_q, arb_d;

    assign pick1 = nonempty[1] && (!nonempty[0] || arb_q == PREFER1);

    // Preference flips only after a contended pop
    always_comb begin
        arb_d = arb_q;
        if (pop && nonempty[0] && nonempty[1]) begin
            arb_d = pick1 ? PREFER0 : PREFER1;
        end
    end

    // Round-robin preference register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            arb_q <= PREFER0;
        end else begin
            arb_q <= arb_d;
        end
    end
`endif

    // Write stage: register the popped entry; register 0 never writes
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rf_wen_q  <= 1'b0;
            rf_wsel_q <= '0;
            rf_wdat_q <= '0;
            grant_q   <= 1'b0;
        end else if (pop) begin
            rf_wen_q  <= (sel_req.wsel != '0);
            rf_wsel_q <= sel_req.wsel;
            rf_wdat_q <= sel_req.wdat;
            grant_q   <= pick1;
        end else begin
            rf_wen_q  <= 1'b0;
        end
    end

    // Pending mask over queued entries and the staged write
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (vld0[i]) pending_c = pending_c | reg_onehot(ent0[i]);
            if (vld1[i]) pending_c = pending_c | reg_onehot(ent1[i]);
        end
        if (rf_wen_q) pending_c = pending_c | reg_onehot(rf_wsel_q);
    end

    assign rf_WEN   = rf_wen_q;
    assign rf_wsel  = rf_wsel_q;
    assign rf_wdat  = rf_wdat_q;
    assign grant_id = grant_q;
    assign pending  = pending_c;
    assign idle     = empty0 && empty1 && !rf_wen_q;

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Shares the register file's single write port between two writeback requesters: port 0 (ALU/execute) and port 1 (memory/load return).
- Each requester has a valid/ready handshake into a private FIFO. A round-robin arbiter drains one FIFO head per cycle into a registered write stage that drives WEN/wsel/wdat on the register file.
- Exports a per-register pending mask, which the hazard unit uses to stall dependent reads.

Parameters:
- FIFO_DEPTH, 2, entries per requester FIFO; power of 2, at least 2.
- NREQ, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- flush  in  1  synchronous; empties both FIFOs
- wb0_valid  in  1  port 0 request
- wb0_ready  out  1  port 0 FIFO not full
- wb0_wsel  in  5  port 0 destination register
- wb0_wdat  in  32  port 0 data
- wb1_valid / wb1_ready / wb1_wsel / wb1_wdat  as port 0, for port 1
- rf_WEN  out  1  register file write enable
- rf_wsel  out  5  register file write select
- rf_wdat  out  32  register file write data
- grant_id  out  1  source port of the current rf_* write
- pending  out  32  bit r set while a write to register r is queued or staged
- idle  out  1  both FIFOs empty and rf_WEN low

Behaviour:
- Reset values: reset is asynchronous, active-low on n_rst, clocked by clk.
  - FIFOs empty.
  - rf_WEN=0, rf_wsel=0, rf_wdat=0, grant_id=0.
  - Round-robin pointer favours port 0.
  - pending=0, idle=1, wbN_ready=1.
- Handshake:
  - A request is accepted at an edge where wbN_valid && wbN_ready.
  - wbN_ready = !fullN; it is combinational from FIFO state only, never from valid.
  - Valid may drop without acceptance.
- Simultaneous events: a push into a full FIFO concurrent with a pop from the same FIFO is not accepted, because ready is low when full.
- Arbiter states: PREFER0 and PREFER1.
  - If only one FIFO is non-empty, pop that one.
  - If both are non-empty, pop the preferred port, then switch preference to the other port.
  - If neither is non-empty, no pop and the state holds.
- Write stage: the popped entry is registered.
  - rf_WEN=1, rf_wsel=entry.wsel, rf_wdat=entry.wdat, grant_id=port, all valid in the cycle after the pop.
  - rf_WEN=0 in cycles with no pop; rf_wsel/rf_wdat hold their values.
- Latency: accepted at edge k into an empty FIFO → popped at edge k+1 → register file written at edge k+2. Throughput is 1 write per cycle total.
- Register 0: a wsel=0 entry is accepted and popped normally but produces rf_WEN=0. It never sets pending[0].
- pending is combinational: OR over all valid FIFO entries and the staged write (when rf_WEN=1) of one-hot(wsel).
- Ordering:
  - Preserved within a port.
  - Not guaranteed across ports; the hazard unit must not issue a second write to r while pending[r]=1.
- flush:
  - At the edge where flush=1, both FIFOs are cleared.
  - A write already staged (rf_WEN=1) still completes.
  - No pop occurs that cycle.
  - Same-cycle pushes are dropped.
  - wbN_ready=1 the following cycle.
- Reset mid-operation: all queued and staged writes are discarded immediately. rf_WEN drops asynchronously.

Optional Feature:
- Macro: RF_WB_FIXED_PRIORITY_EN.
- Defined: the arbiter always prefers port 0 when both FIFOs are non-empty, and the PREFER state register is removed. Port 1 may starve, which is acceptable when port 0 is known to be bursty.
- Not defined: round-robin as above.

Decomposition:
- cpu_types_pkg:
  - wb_req_t struct {regbits_t wsel; word_t wdat;}.
  - localparam WB_NREQ=2.
  - enum wb_arb_t {PREFER0, PREFER1}.
  - Reuses word_t and regbits_t.
- Sub-module: wb_fifo (parameterised depth, push/pop/flush, full/empty, exposes entry array and valid bits for pending). Instantiated twice; arbiter and write stage live in rf_wb_scheduler.

Test Plan:
- Single write: wb0 valid wsel=5 wdat=0xDEADBEEF at edge 1 → pending[5]=1 after edge 1; rf_WEN=1, rf_wsel=5, rf_wdat=0xDEADBEEF, grant_id=0 after edge 2; pending[5]=0 and idle=1 after edge 3.
- Contention RR: both ports continuously valid, port 0 to regs 1..4, port 1 to regs 11..14 → rf_wsel sequence 1,11,2,12,3,13,4,14; grant_id alternates 0,1.
- Backpressure: port 1 pushes 3 entries while port 0 floods and FIFO_DEPTH=2 → wb1_ready=0 after 2 accepted; no entry lost or duplicated; all 3 appear on rf_wsel in order.
- Register 0: wb1 wsel=0 wdat=0x1234 → entry popped, rf_WEN stays 0, pending stays 0.
- Flush: 2 entries queued on each port plus one staged, then flush=1 → the staged write completes; no further rf_WEN; pending clears except the staged reg during its cycle; ready=1 the next cycle.
- Async reset mid-stream: n_rst=0 while rf_WEN=1 and FIFOs non-empty → rf_WEN=0 immediately, pending=0, idle=1; after release, the first new request follows the 2-edge latency.
